booth_r16_accumulate_unit: RTL and testbench

//  Consumer end of the radix-16 multiplicand preprocessing interface: takes the registered
//  1X/3X/5X/7X multiples of the multiplicand plus the signed multiplier operand, Booth-recodes
//  the multiplier into radix-16 digits (-8..+8) and builds the signed product sequentially,
//  one digit per clock. Sits directly downstream of one output port of the preprocess unit
//  in the fixed-point multiplier datapath.

---
 rtl/booth_r16_accumulate_unit.sv | 106 ++++++++++
 tb/tb_booth_r16_accumulate_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_r16_accumulate_unit.sv
// Radix-16 Booth sequential multiplier: recodes one 4-bit multiplier digit per clock and
// accumulates the selected signed multiple of the multiplicand into a PROD_W-bit product.
module booth_r16_accumulate_unit #(
  parameter  int MULR_W = 8,
  localparam int PROD_W = 8 + MULR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iStart,
  input  logic [MULR_W-1:0] iMulr,
  input  logic [7:0]        iDat1X,
  input  logic [9:0]        iDat3X,
  input  logic [10:0]       iDat5X,
  input  logic [10:0]       iDat7X,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oValid,
  output logic [PROD_W-1:0] oProd
);

  localparam int NDIG  = MULR_W / 4;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [MULR_W:0]     mulr_sr;
  logic [CNT_W-1:0]    cnt;
  logic [PROD_W-1:0]   acc, acc_nxt, pp_ext;
  logic [4:0]          dig, dig_neg;
  logic [3:0]          mag;
  logic [11:0]         x1, x3, x5, x7, mult, pp;
  logic                last;

  assign x1 = {{4{iDat1X[7]}}, iDat1X};
  assign x3 = {{2{iDat3X[9]}}, iDat3X};
  assign x5 = {iDat5X[10], iDat5X};
  assign x7 = {iDat7X[10], iDat7X};

  // Low five bits of the shift register are {b3,b2,b1,b0,b(-1)} of the current digit.
  always_comb begin
    dig     = {mulr_sr[4], mulr_sr[4:1]} + {4'b0000, mulr_sr[0]};
    dig_neg = -dig;
    mag     = dig[4] ? dig_neg[3:0] : dig[3:0];
    case (mag)
      4'd1:    mult = x1;
      4'd2:    mult = x1 << 1;
      4'd3:    mult = x3;
      4'd4:    mult = x1 << 2;
      4'd5:    mult = x5;
      4'd6:    mult = x3 << 1;
      4'd7:    mult = x7;
      4'd8:    mult = x1 << 3;
      default: mult = 12'd0;
    endcase
    pp      = dig[4] ? -mult : mult;
    pp_ext  = {{(PROD_W-12){pp[11]}}, pp};
    acc_nxt = acc + (pp_ext << {cnt, 2'b00});
    last    = (cnt == CNT_W'(NDIG - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    if (iReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mulr_sr <= '0;
      cnt     <= '0;
      acc     <= '0;
      oValid  <= 1'b0;
      oProd   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (iStart) begin
          mulr_sr <= {iMulr, 1'b0};
          acc     <= '0;
          cnt     <= '0;
        end
        RUN: begin
          acc     <= acc_nxt;
          mulr_sr <= {{4{mulr_sr[MULR_W]}}, mulr_sr[MULR_W:4]};
          if (last) begin
            oProd  <= acc_nxt;
            oValid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: if (iReady) oValid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_booth_r16_accumulate_unit.sv
// Self-checking bench: vector table, hand-written hold/reset sequences and random pairs,
// with expected products queued at start and popped when oValid appears.
module tb_booth_r16_accumulate_unit;

  logic        clk = 1'b0;
  logic        rst, iStart, iReady;
  logic [7:0]  iMulr, iDat1X;
  logic [9:0]  iDat3X;
  logic [10:0] iDat5X, iDat7X;
  logic        oBusy, oValid;
  logic [15:0] oProd;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct { int a; int m; int p; } vec_t;
  vec_t vecs[10];

  booth_r16_accumulate_unit #(.MULR_W(8)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iMulr(iMulr),
    .iDat1X(iDat1X), .iDat3X(iDat3X), .iDat5X(iDat5X), .iDat7X(iDat7X),
    .iReady(iReady), .oBusy(oBusy), .oValid(oValid), .oProd(oProd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start(input int a, input int m);
    iDat1X = 8'(a);
    iDat3X = 10'(3 * a);
    iDat5X = 11'(5 * a);
    iDat7X = 11'(7 * a);
    iMulr  = 8'(m);
    iStart = 1'b1;
    exp_q.push_back(a * m);
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!oValid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_result(input string name);
    int req;
    wait_valid();
    req = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
    check({name, " valid"}, int'(oValid), 1);
    check({name, " prod"}, int'($signed(oProd)), req);
    iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
  endtask

  initial begin
    logic signed [7:0] ra, rm;

    vecs[0] = '{5, 3, 15};
    vecs[1] = '{-128, -128, 16384};
    vecs[2] = '{127, 127, 16129};
    vecs[3] = '{127, -128, -16256};
    vecs[4] = '{-1, -1, 1};
    vecs[5] = '{0, -77, 0};
    vecs[6] = '{-128, 127, -16256};
    vecs[7] = '{1, -128, -128};
    vecs[8] = '{-7, 8, -56};
    vecs[9] = '{100, -3, -300};

    rst = 1'b1; iStart = 1'b0; iReady = 1'b0; iMulr = '0;
    iDat1X = '0; iDat3X = '0; iDat5X = '0; iDat7X = '0;
    repeat (2) @(negedge clk);
    check("reset busy", int'(oBusy), 0);
    check("reset valid", int'(oValid), 0);
    check("reset prod", int'($signed(oProd)), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: start edge t, oValid low after t and t+1, high after t+2.
    start(5, 3);
    check("t1 busy", int'(oBusy), 1);
    check("t1 valid t", int'(oValid), 0);
    @(negedge clk);
    check("t1 valid t+1", int'(oValid), 0);
    @(negedge clk);
    check("t1 valid t+2", int'(oValid), 1);
    wait_result("t1");

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].m);
      if (exp_q.size() != 0) exp_q[exp_q.size()-1] = vecs[i].p;
      wait_result($sformatf("vec%0d", i));
    end

    // Result held while iReady low; starts ignored in DONE and RUN.
    start(-3, 7);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("t4 hold valid", int'(oValid), 1);
      check("t4 hold prod", int'($signed(oProd)), -21);
      iStart = (i % 2 == 0);
      iMulr  = 8'(i + 40);
      @(negedge clk);
    end
    iStart = 1'b0;
    check("t4 still valid", int'(oValid), 1);
    check("t4 still prod", int'($signed(oProd)), -21);
    void'(exp_q.pop_front());
    iReady = 1'b1;
    iStart = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
    iStart = 1'b0;
    check("t4 valid drop", int'(oValid), 0);
    check("t4 idle", int'(oBusy), 0);
    check("t4 prod kept", int'($signed(oProd)), -21);
    start(12, -5);
    iStart = 1'b1;
    iMulr  = 8'd1;
    @(negedge clk);
    iStart = 1'b0;
    wait_result("t4 next");

    // Reset during the first RUN cycle aborts with no partial result.
    start(5, 3);
    void'(exp_q.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 busy", int'(oBusy), 0);
    check("t5 valid", int'(oValid), 0);
    check("t5 prod", int'($signed(oProd)), 0);
    repeat (3) @(negedge clk);
    check("t5 no late valid", int'(oValid), 0);
    start(-1, -1);
    wait_result("t5 fresh");

    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rm = 8'($urandom);
      start(int'(ra), int'(rm));
      wait_result("rand");
      if (errors > 20) break;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
